mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_divstep.sv | 27 ++
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants, FSM encoding and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = 5;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  // Absolute value when the operand is treated as signed, pass-through otherwise.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift next dividend bit into the remainder, subtract if it fits.
module mdu_divstep
  import mdu_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic            fits;

  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    fits    = (shifted >= {1'b0, divisor});
    if (fits) begin
      rem_out = DATA_W'(shifted - {1'b0, divisor});
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide, sign fix-up.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        operation,
  input  logic [DATA_W-1:0] operando_1,
  input  logic [DATA_W-1:0] operando_2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdu_state_e          state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_reg;     // multiplicand magnitude, or raw dividend for divide
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] prod;      // product, or {remainder, quotient} while dividing
  logic                neg_a, neg_b, is_div;

  logic                is_mul_op, is_div_op, is_move_op, accept;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   div_rem, div_quo;
  logic [2*DATA_W-1:0] mul_fixed;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  mdu_divstep u_divstep (
    .rem_in  (prod[2*DATA_W-1:DATA_W]),
    .quo_in  (prod[DATA_W-1:0]),
    .divisor (b_mag),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  // Request decode, datapath step and sign correction.
  always_comb begin
    is_mul_op  = (operation == F_MULT) || (operation == F_MULTU);
    is_div_op  = (operation == F_DIV)  || (operation == F_DIVU);
    is_move_op = (operation == F_MFHI) || (operation == F_MTHI) ||
                 (operation == F_MFLO) || (operation == F_MTLO);
    accept     = start && (state == S_IDLE);

    mul_sum    = {1'b0, prod[2*DATA_W-1:DATA_W]} +
                 (prod[0] ? {1'b0, a_reg} : (DATA_W+1)'(0));

    mul_fixed  = (neg_a ^ neg_b) ? (2*DATA_W)'(-prod) : prod;
    if (!is_div) begin
      fix_hi = mul_fixed[2*DATA_W-1:DATA_W];
      fix_lo = mul_fixed[DATA_W-1:0];
    end else if (b_mag == '0) begin
      fix_hi = a_reg;
      fix_lo = '1;
    end else begin
      fix_hi = neg_a ? DATA_W'(-prod[2*DATA_W-1:DATA_W]) : prod[2*DATA_W-1:DATA_W];
      fix_lo = (neg_a ^ neg_b) ? DATA_W'(-prod[DATA_W-1:0]) : prod[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul_op)      next_state = S_MUL;
        else if (accept && is_div_op) next_state = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == CNT_W'(ITERATIONS - 1)) next_state = S_FIX;
      end
      S_FIX:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_mag <= '0;
      prod  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      is_div <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == S_MUL) || (next_state == S_DIV) || (next_state == S_FIX);
      done  <= (state == S_FIX) || (accept && is_move_op);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept && is_mul_op) begin
            a_reg  <= mag32(operando_1, operation == F_MULT);
            b_mag  <= mag32(operando_2, operation == F_MULT);
            prod   <= {{DATA_W{1'b0}}, mag32(operando_2, operation == F_MULT)};
            neg_a  <= (operation == F_MULT) && operando_1[DATA_W-1];
            neg_b  <= (operation == F_MULT) && operando_2[DATA_W-1];
            is_div <= 1'b0;
          end else if (accept && is_div_op) begin
            a_reg  <= operando_1;
            b_mag  <= mag32(operando_2, operation == F_DIV);
            prod   <= {{DATA_W{1'b0}}, mag32(operando_1, operation == F_DIV)};
            neg_a  <= (operation == F_DIV) && operando_1[DATA_W-1];
            neg_b  <= (operation == F_DIV) && operando_2[DATA_W-1];
            is_div <= 1'b1;
          end else if (accept && operation == F_MTHI) begin
            hi <= operando_1;
          end else if (accept && operation == F_MTLO) begin
            lo <= operando_1;
          end
        end
        S_MUL: begin
          prod <= {mul_sum, prod[DATA_W-1:1]};
          cnt  <= cnt + CNT_W'(1);
        end
        S_DIV: begin
          prod <= {div_rem, div_quo};
          cnt  <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of iterative ops plus move/reset/overlap sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  operation;
  logic [31:0] operando_1, operando_2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .operation  (operation),
    .operando_1 (operando_1),
    .operando_2 (operando_2),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s [%0d]: got %h expected %h", name, tag, act, exp);
    end
  endtask

  // Issue one iterative request and check timing and result; optionally inject a stray start.
  task automatic run_iter(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int tag, input int intrude_cyc);
    int busy_bad = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic busy34 = 1'b1;
    logic [31:0] hi34 = '0, lo34 = '0;
    @(negedge clk);
    start = 1'b1; operation = op; operando_1 = a; operando_2 = b;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= 33 && (busy !== 1'b1 || done !== 1'b0)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 34) begin busy34 = busy; hi34 = hi; lo34 = lo; end
      if (c == 1) begin
        start = 1'b0; operando_1 = ~a; operando_2 = a ^ b ^ 32'h5A5A_A5A5;
      end
      if (intrude_cyc > 0 && c == intrude_cyc) begin
        start = 1'b1; operation = F_MULT; operando_1 = 32'd3; operando_2 = 32'd5;
      end
      if (intrude_cyc > 0 && c == intrude_cyc + 1) start = 1'b0;
    end
    check("busy_cycles_1_33_bad", tag, 64'(busy_bad), 64'd0);
    check("done_pulse_count",     tag, 64'(done_cnt), 64'd1);
    check("done_cycle",           tag, 64'(done_cyc), 64'd34);
    check("busy_at_done",         tag, 64'(busy34),   64'd0);
    check("hi",                   tag, 64'(hi34),     64'(exp_hi));
    check("lo",                   tag, 64'(lo34),     64'(exp_lo));
  endtask

  // Single-cycle request; checks done/busy/hi/lo in cycle 1.
  task automatic run_move(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_done, input int tag);
    @(negedge clk);
    start = 1'b1; operation = op; operando_1 = a; operando_2 = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check("move_done", tag, 64'(done), 64'(exp_done));
    check("move_busy", tag, 64'(busy), 64'd0);
    check("move_hi",   tag, 64'(hi),   64'(exp_hi));
    check("move_lo",   tag, 64'(lo),   64'(exp_lo));
    @(negedge clk);
    check("move_done_drop", tag, 64'(done), 64'd0);
  endtask

  initial begin
    int done_seen;
    int busy_seen;

    vecs[0]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{F_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{F_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[6]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{F_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF};
    vecs[10] = '{F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[11] = '{F_DIVU,  32'd10,       32'd3,        32'd1,        32'd3};

    reset = 1'b1; start = 1'b0; operation = '0; operando_1 = '0; operando_2 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 0, 64'(busy), 64'd0);
    check("reset_done", 0, 64'(done), 64'd0);
    check("reset_hi",   0, 64'(hi),   64'd0);
    check("reset_lo",   0, 64'(lo),   64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_iter(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, i, 0);

    // Moves and an unsupported opcode; hi/lo currently hold 1 / 3 from the last vector.
    run_move(F_MTLO,    32'h12345678, 32'd1,        32'h12345678, 1'b1, 100);
    run_move(F_MFLO,    32'hCAFEF00D, 32'd1,        32'h12345678, 1'b1, 101);
    run_move(F_MTHI,    32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678, 1'b1, 102);
    run_move(F_MFHI,    32'h0,        32'hA5A5A5A5, 32'h12345678, 1'b1, 103);
    run_move(6'b100000, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h12345678, 1'b0, 104);

    // Reset at cycle 15 of a DIVU, with a start in the same cycle.
    @(negedge clk);
    start = 1'b1; operation = F_DIVU; operando_1 = 32'd10; operando_2 = 32'd3;
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    reset = 1'b1; start = 1'b1; operation = F_MTLO; operando_1 = 32'hDEADBEEF;
    @(negedge clk);
    check("midreset_hi",   200, 64'(hi),   64'd0);
    check("midreset_lo",   200, 64'(lo),   64'd0);
    check("midreset_busy", 200, 64'(busy), 64'd0);
    check("midreset_done", 200, 64'(done), 64'd0);
    reset = 1'b0; start = 1'b0;
    done_seen = 0; busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    check("abandoned_done", 201, 64'(done_seen), 64'd0);
    check("abandoned_busy", 201, 64'(busy_seen), 64'd0);
    run_iter(F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 202, 0);

    // Stray MULT start at cycle 5 of a DIVU must be ignored.
    run_iter(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 300, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
